floor_request_encoder: RTL and testbench

Captures the three hall/cab floor buttons, debounces and latches them as pending requests, and offers one encoded target floor at a time to the elevator controller over a valid/ack handshake. It is the input-side counterpart of the next-floor LED decoder. That decoder turns a 4-bit floor code into a one-hot lamp; this block turns one-hot buttons into the same 4-bit floor code (floor n ↔ 4'b000n ↔ one-hot bit n). It sits between the board buttons and the controller's next-floor input, and it drives the request lamps.

---
 rtl/floor_request_encoder.sv | 181 ++++++++++++++++++
 tb/tb_floor_request_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_encoder
//  Description : Synchronizes and debounces three floor buttons, latches them
//                as pending requests (request lamps) and offers the nearest
//                pending floor, as a 4-bit floor code, to the elevator
//                controller over a valid/ack handshake.
//  Ports       : new_clock     - system clock, rising edge
//                reset         - synchronous, active-high
//                btn[2:0]      - raw asynchronous buttons, bit n = floor n
//                current_floor - controller's present floor code (0..2 valid)
//                ack           - controller accepts the offered floor
//                req_floor     - offered floor code (registered)
//                req_valid     - offer is active (registered)
//                pending[2:0]  - outstanding requests, one-hot per floor
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_request_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       new_clock,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [3:0] current_floor,
  input  logic       ack,
  output logic [3:0] req_floor,
  output logic       req_valid,
  output logic [2:0] pending
);

  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [2:0] press_set;

  // --------------------------------------------------------------------------
  // Per-button input path: 2-flop synchronizer, saturating stable-high
  // counter and an armed flag that allows one registration per press.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       armed_q, armed_d;
    logic [3:0] cnt_q, cnt_d;
    logic       press;

    always_comb begin
      sync1_d = btn[gi];
      sync2_d = sync1_q;
      press   = 1'b0;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (!sync2_q) begin
        cnt_d   = 4'd0;
        armed_d = 1'b1;
      end else begin
        // Fire on the sample that brings the counter to DEBOUNCE_CYCLES, so
        // the pending bit appears in the same cycle the counter saturates.
        press   = armed_q && (cnt_q >= DEB_LAST);
        cnt_d   = (cnt_q < DEB_MAX) ? cnt_q + 4'd1 : cnt_q;
        armed_d = armed_q && !press;
      end
    end

    always_ff @(posedge new_clock) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= 4'd0;
        armed_q <= 1'b1;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
      end
    end

    assign press_set[gi] = press;
  end : g_btn

  // --------------------------------------------------------------------------
  // Request latch, target selection and offer FSM
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic       dir_up_q, dir_up_d;
  logic [2:0] pending_q, pending_d;
  logic [3:0] req_floor_q, req_floor_d;
  logic       req_valid_q, req_valid_d;

  logic [1:0] sel_floor;
  logic [1:0] best_dist;
  logic [1:0] cand_dist;
  logic [1:0] cand_floor;
  logic       found;
  logic [2:0] clr;

  // Nearest pending floor. Floors are scanned upward; an equal distance only
  // replaces the earlier (lower) candidate when travelling up, which resolves
  // the single possible tie (floors 0 and 2 from floor 1) toward dir.
  always_comb begin
    sel_floor  = 2'd0;
    best_dist  = 2'd3;
    cand_dist  = 2'd0;
    cand_floor = 2'd0;
    found      = 1'b0;
    for (int f = 0; f < 3; f++) begin
      cand_floor = 2'(f);
      cand_dist  = (cand_floor >= current_floor[1:0]) ?
                   cand_floor - current_floor[1:0] :
                   current_floor[1:0] - cand_floor;
      if (pending_q[f] &&
          (!found || (cand_dist < best_dist) ||
           ((cand_dist == best_dist) && dir_up_q))) begin
        sel_floor = cand_floor;
        best_dist = cand_dist;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    clr         = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if ((pending_q != 3'b000) && (current_floor <= 4'd2)) begin
          req_floor_d = {2'b00, sel_floor};
          req_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (ack) begin
          clr         = 3'b001 << req_floor_q[1:0];
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (req_floor_q > current_floor) begin
            dir_up_d = 1'b1;
          end else if (req_floor_q < current_floor) begin
            dir_up_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The ack clear is applied after the set, so a press completing on the
    // acknowledged floor in the same cycle is consumed.
    pending_d = (pending_q | press_set) & ~clr;
  end

  always_ff @(posedge new_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_up_q    <= 1'b1;
      pending_q   <= 3'b000;
      req_floor_q <= 4'b0000;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign pending   = pending_q;

endmodule : floor_request_encoder
`default_nettype wire

// File: tb/tb_floor_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floor_request_encoder
//  Description : Self-checking bench for floor_request_encoder. A behavioural
//                model (button sample history, run lengths of high samples,
//                distance search over pending floors) predicts the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_request_encoder;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic [3:0] cur;
  logic       ack;
  logic [3:0] req_floor;
  logic       req_valid;
  logic [2:0] pending;

  int vectors = 0;
  int errs    = 0;

  // Reference model state
  logic [2:0] hist0, hist1;
  int         run [3];
  logic [2:0] m_pend;
  logic       m_rv;
  logic [3:0] m_rf;
  bit         m_up;

  floor_request_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .new_clock    (clk),
    .reset        (rst),
    .btn          (btn),
    .current_floor(cur),
    .ack          (ack),
    .req_floor    (req_floor),
    .req_valid    (req_valid),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nearest pending floor by growing search radius; tie goes toward dir.
  function automatic logic [3:0] pick(input logic [2:0] p, input logic [3:0] c, input bit up);
    int ci, lo, hi;
    bit has_lo, has_hi;
    ci = int'(c);
    for (int d = 0; d <= 2; d++) begin
      lo = ci - d;
      hi = ci + d;
      has_lo = (lo >= 0) && (lo <= 2) && (p[lo] == 1'b1);
      has_hi = (hi >= 0) && (hi <= 2) && (p[hi] == 1'b1);
      if (has_lo && has_hi && (lo != hi)) return up ? 4'(hi) : 4'(lo);
      if (has_hi) return 4'(hi);
      if (has_lo) return 4'(lo);
    end
    return 4'd0;
  endfunction

  // Advance the model by one clock with the inputs currently driven, then
  // let the DUT take the same edge.
  task automatic tick();
    logic [2:0] fire, clr, v;
    fire = 3'b000;
    clr  = 3'b000;
    if (rst) begin
      hist0 = 3'b000;
      hist1 = 3'b000;
      for (int n = 0; n < 3; n++) run[n] = 0;
      m_pend = 3'b000;
      m_rv   = 1'b0;
      m_rf   = 4'd0;
      m_up   = 1'b1;
    end else begin
      v = hist1;
      for (int n = 0; n < 3; n++) begin
        if (v[n]) run[n]++;
        else run[n] = 0;
        fire[n] = (run[n] == DEB);
      end
      hist1 = hist0;
      hist0 = btn;
      if (!m_rv) begin
        if (m_pend != 3'b000 && cur <= 4'd2) begin
          m_rf = pick(m_pend, cur, m_up);
          m_rv = 1'b1;
        end
      end else if (ack) begin
        clr[m_rf[1:0]] = 1'b1;
        m_rv = 1'b0;
        if (m_rf > cur) m_up = 1'b1;
        else if (m_rf < cur) m_up = 1'b0;
      end
      m_pend = (m_pend | fire) & ~clr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask);
    btn = mask;
    repeat (DEB + 3) tick();
    btn = 3'b000;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 3'b000; cur = 4'd0; ack = 1'b0;
    tick(); tick();
    if ({req_valid, req_floor, pending} !== 8'h00) begin
      errs++;
      $display("FAIL reset got v=%b f=%0d p=%b exp v=0 f=0 p=000", req_valid, req_floor, pending);
    end
    vectors++;
  endtask

  task automatic test_basic();
    rst = 1'b0; btn = 3'b100; cur = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if ({req_valid, req_floor, pending} !== {m_rv, m_rf, m_pend}) begin
        errs++;
        $display("FAIL basic_model cyc=%0d got v=%b f=%0d p=%b exp v=%b f=%0d p=%b",
                 k, req_valid, req_floor, pending, m_rv, m_rf, m_pend);
      end
      vectors++;
      if (k == 5 && pending !== 3'b000) begin
        errs++; $display("FAIL basic_early got p=%b exp 000", pending);
      end
      if (k == 6 && (pending !== 3'b100 || req_valid !== 1'b0)) begin
        errs++; $display("FAIL basic_pend got p=%b v=%b exp p=100 v=0", pending, req_valid);
      end
      if (k == 7 && (req_valid !== 1'b1 || req_floor !== 4'b0010)) begin
        errs++; $display("FAIL basic_offer got v=%b f=%0d exp v=1 f=2", req_valid, req_floor);
      end
      if (k == 10 && (pending !== 3'b000 || req_valid !== 1'b0)) begin
        errs++; $display("FAIL basic_ack got p=%b v=%b exp p=000 v=0", pending, req_valid);
      end
      if (k == 5 || k == 6 || k == 7 || k == 10) vectors++;
      ack = (k == 9);
    end
    ack = 1'b0; btn = 3'b000;
    repeat (3) tick();
  endtask

  task automatic test_debounce();
    logic [6:0] pat;
    pat = 7'b1110111;
    cur = 4'hF;
    for (int k = 6; k >= 0; k--) begin
      btn = {1'b0, pat[k], 1'b0};
      tick();
    end
    btn = 3'b000;
    repeat (4) tick();
    if (pending !== 3'b000) begin
      errs++; $display("FAIL debounce_glitch got p=%b exp 000", pending);
    end
    vectors++;
    btn = 3'b010;
    repeat (6) tick();
    if (pending !== 3'b010) begin
      errs++; $display("FAIL debounce_held got p=%b exp 010", pending);
    end
    vectors++;
    cur = 4'd0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0; cur = 4'hF;
    repeat (8) tick();
    if (pending !== 3'b000 || req_valid !== 1'b0) begin
      errs++; $display("FAIL debounce_once got p=%b v=%b exp p=000 v=0", pending, req_valid);
    end
    vectors++;
    btn = 3'b000;
    repeat (3) tick();
  endtask

  task automatic test_nearest_tie();
    cur = 4'hF;
    press(3'b110);
    cur = 4'd0; tick();
    if (req_valid !== 1'b1 || req_floor !== 4'd1) begin
      errs++; $display("FAIL nearest got v=%b f=%0d exp v=1 f=1", req_valid, req_floor);
    end
    vectors++;
    ack = 1'b1; tick(); ack = 1'b0; cur = 4'hF; tick();
    press(3'b001);
    cur = 4'd1; tick();
    if (req_valid !== 1'b1 || req_floor !== 4'd2) begin
      errs++; $display("FAIL tie_up got v=%b f=%0d exp v=1 f=2", req_valid, req_floor);
    end
    vectors++;
    ack = 1'b1; tick(); ack = 1'b0; cur = 4'hF; tick();
    cur = 4'd2; tick();
    ack = 1'b1; tick(); ack = 1'b0; cur = 4'hF; tick();
    press(3'b101);
    cur = 4'd1; tick();
    if (req_valid !== 1'b1 || req_floor !== 4'd0) begin
      errs++; $display("FAIL tie_down got v=%b f=%0d exp v=1 f=0", req_valid, req_floor);
    end
    vectors++;
    ack = 1'b1; tick(); ack = 1'b0; cur = 4'hF; tick();
    if (pending !== 3'b100 || req_valid !== 1'b0) begin
      errs++; $display("FAIL tie_left got p=%b v=%b exp p=100 v=0", pending, req_valid);
    end
    vectors++;
  endtask

  task automatic test_offer_stability();
    cur = 4'd0; tick();
    btn = 3'b001;
    for (int k = 0; k < DEB + 6; k++) begin
      if (k == DEB + 3) btn = 3'b000;
      tick();
      if (req_valid !== 1'b1 || req_floor !== 4'd2) begin
        errs++; $display("FAIL stable_hold cyc=%0d got v=%b f=%0d exp v=1 f=2", k, req_valid, req_floor);
      end
      vectors++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
    if (req_valid !== 1'b0 || pending !== 3'b001) begin
      errs++; $display("FAIL stable_ack got v=%b p=%b exp v=0 p=001", req_valid, pending);
    end
    vectors++;
    tick();
    if ({req_valid, req_floor, pending} !== {m_rv, m_rf, m_pend} || req_floor !== 4'd0 || req_valid !== 1'b1) begin
      errs++; $display("FAIL stable_next got v=%b f=%0d exp v=1 f=0", req_valid, req_floor);
    end
    vectors++;
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_collision();
    cur = 4'hF;
    press(3'b010);
    cur = 4'd1; tick();
    btn = 3'b010;
    repeat (DEB + 1) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    if (pending !== 3'b000 || req_valid !== 1'b0) begin
      errs++; $display("FAIL collision got p=%b v=%b exp p=000 v=0", pending, req_valid);
    end
    vectors++;
    repeat (3) tick();
    btn = 3'b000;
    repeat (3) tick();
    if (pending !== 3'b000) begin
      errs++; $display("FAIL collision_consumed got p=%b exp 000", pending);
    end
    vectors++;
    cur = 4'hF;
    press(3'b001);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    if (pending !== 3'b001 || req_valid !== 1'b0) begin
      errs++; $display("FAIL idle_ack got p=%b v=%b exp p=001 v=0", pending, req_valid);
    end
    vectors++;
  endtask

  task automatic test_invalid_floor();
    cur = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (req_valid !== 1'b0 || pending !== 3'b001) begin
        errs++; $display("FAIL invalid_floor cyc=%0d got v=%b p=%b exp v=0 p=001", k, req_valid, pending);
      end
      vectors++;
    end
    cur = 4'd0; tick();
    if (req_valid !== 1'b1 || req_floor !== 4'd0) begin
      errs++; $display("FAIL invalid_recover got v=%b f=%0d exp v=1 f=0", req_valid, req_floor);
    end
    vectors++;
  endtask

  task automatic test_reset_mid_offer();
    btn = 3'b010;
    rst = 1'b1; tick();
    if ({req_valid, req_floor, pending} !== 8'h00) begin
      errs++; $display("FAIL reset_mid got v=%b f=%0d p=%b exp v=0 f=0 p=000", req_valid, req_floor, pending);
    end
    vectors++;
    rst = 1'b0; btn = 3'b000;
    repeat (4) tick();
    if (pending !== 3'b000 || req_valid !== 1'b0) begin
      errs++; $display("FAIL reset_after got p=%b v=%b exp p=000 v=0", pending, req_valid);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      for (int n = 0; n < 3; n++) if ($urandom_range(0, 9) == 0) btn[n] = ~btn[n];
      if ($urandom_range(0, 15) == 0) cur = 4'($urandom_range(0, 15));
      else if (cur > 4'd2 && $urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 2));
      ack = m_rv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      if ({req_valid, req_floor, pending} !== {m_rv, m_rf, m_pend}) begin
        errs++;
        $display("FAIL random cyc=%0d got v=%b f=%0d p=%b exp v=%b f=%0d p=%b",
                 k, req_valid, req_floor, pending, m_rv, m_rf, m_pend);
      end
      vectors++;
    end
    rst = 1'b0; ack = 1'b0; btn = 3'b000;
  endtask

  initial begin
    rst = 1'b1; btn = 3'b000; cur = 4'd0; ack = 1'b0;
    hist0 = 3'b000; hist1 = 3'b000;
    for (int n = 0; n < 3; n++) run[n] = 0;
    m_pend = 3'b000; m_rv = 1'b0; m_rf = 4'd0; m_up = 1'b1;
    test_reset();
    test_basic();
    test_debounce();
    test_nearest_tie();
    test_offer_stability();
    test_collision();
    test_invalid_floor();
    test_reset_mid_offer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_floor_request_encoder
`default_nettype wire
